conv_pool_relu_stream: RTL and testbench

- Downstream stage of the convolution top. Consumes the flat OUT×OUT 16-bit result bus once the convolver signals completion.
- Performs 2×2 stride-2 max-pooling, with optional ReLU.
- Holds the pooled map on a flat bus and streams it out element-by-element over a valid/ready interface.

---
 rtl/conv_pool_relu_stream.sv | 193 +++++++++++++++++++
 tb/tb_conv_pool_relu_stream.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_relu_stream.sv
// 2x2 stride-2 max-pool of a flat convolution result, streamed out over valid/ready.
// Optional macro POOL_RELU_EN clamps each pooled value at zero.
module conv_pool_relu_stream #(
  parameter  int OUT      = 7,
  parameter  int DW       = 16,
  localparam int POOL_OUT = OUT / 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            conv_done,
  input  logic [OUT*OUT*DW-1:0]           result,
  output logic [POOL_OUT*POOL_OUT*DW-1:0] pool_result,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DW-1:0]                   out_data,
  output logic                            out_last,
  output logic                            busy,
  output logic                            pool_done
);

  localparam int NPOOL = POOL_OUT * POOL_OUT;
  localparam int IW    = (NPOOL > 1) ? $clog2(NPOOL) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NPOOL - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_POOL   = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_conv_done_q;
  logic [OUT*OUT*DW-1:0] r_result;
  logic [NPOOL*DW-1:0]   r_pool;
  logic [IW-1:0]         r_idx;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic [DW-1:0]         r_out_data;
  logic                  r_busy;
  logic                  r_pool_done;

  logic                  w_trigger;
  logic                  w_xfer;
  logic [IW-1:0]         w_idx_inc;
  logic [DW-1:0]         w_pooled [NPOOL];
  logic [DW-1:0]         w_pool_sel;
  logic [DW-1:0]         w_stream_first;
  logic [DW-1:0]         w_stream_next;
  logic                  w_unused_result;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

  for (genvar gr = 0; gr < POOL_OUT; gr++) begin : g_row
    for (genvar gc = 0; gc < POOL_OUT; gc++) begin : g_col
      localparam int B00 = ((2 * gr) * OUT + 2 * gc) * DW;
      localparam int B01 = B00 + DW;
      localparam int B10 = B00 + OUT * DW;
      localparam int B11 = B10 + DW;
      logic signed [DW-1:0] w_max;
      assign w_max = smax(smax(r_result[B00 +: DW], r_result[B01 +: DW]),
                          smax(r_result[B10 +: DW], r_result[B11 +: DW]));
`ifdef POOL_RELU_EN
      assign w_pooled[gr*POOL_OUT+gc] = w_max[DW-1] ? {DW{1'b0}} : w_max;
`else
      assign w_pooled[gr*POOL_OUT+gc] = w_max;
`endif
    end
  end

  // With odd OUT the last row and column of the captured copy are never read.
  assign w_unused_result = ^r_result;

  assign w_trigger      = conv_done & ~r_conv_done_q;
  assign w_xfer         = r_out_valid & out_ready;
  assign w_idx_inc      = r_idx + {{(IW-1){1'b0}}, 1'b1};
  assign w_pool_sel     = w_pooled[r_idx];
  assign w_stream_first = (NPOOL == 1) ? w_pool_sel : r_pool[DW-1:0];
  assign w_stream_next  = r_pool[int'(w_idx_inc)*DW +: DW];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_next = S_POOL;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_POOL: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = S_STREAM;
        end else begin
          w_state_next = S_POOL;
        end
      end
      S_STREAM: begin
        if (w_xfer && (r_idx == LAST_IDX)) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_STREAM;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Capture, pooling datapath and stream output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_conv_done_q <= 1'b1;
      r_result      <= {(OUT*OUT*DW){1'b0}};
      r_pool        <= {(NPOOL*DW){1'b0}};
      r_idx         <= {IW{1'b0}};
      r_out_valid   <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_data    <= {DW{1'b0}};
      r_busy        <= 1'b0;
      r_pool_done   <= 1'b0;
    end else begin
      r_conv_done_q <= conv_done;
      r_busy        <= (w_state_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_result    <= result;
            r_pool_done <= 1'b0;
            r_idx       <= {IW{1'b0}};
          end
        end
        S_POOL: begin
          r_pool[int'(r_idx)*DW +: DW] <= w_pool_sel;
          if (r_idx == LAST_IDX) begin
            r_idx       <= {IW{1'b0}};
            r_out_valid <= 1'b1;
            r_out_data  <= w_stream_first;
            r_out_last  <= (NPOOL == 1) ? 1'b1 : 1'b0;
          end else begin
            r_idx <= w_idx_inc;
          end
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (r_idx == LAST_IDX) begin
              r_idx       <= {IW{1'b0}};
              r_out_valid <= 1'b0;
              r_out_data  <= {DW{1'b0}};
              r_out_last  <= 1'b0;
            end else begin
              r_idx      <= w_idx_inc;
              r_out_data <= w_stream_next;
              r_out_last <= (w_idx_inc == LAST_IDX);
            end
          end
        end
        S_DONE: begin
          r_pool_done <= 1'b1;
        end
        default: begin
          r_idx <= {IW{1'b0}};
        end
      endcase
    end
  end

  assign pool_result = r_pool;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign out_last    = r_out_last;
  assign busy        = r_busy;
  assign pool_done   = r_pool_done;

endmodule

// File: tb/tb_conv_pool_relu_stream.sv
// Randomized self-checking bench for conv_pool_relu_stream against a plain-arithmetic pooling model.
module tb_conv_pool_relu_stream;

  localparam int OUT = 7;
  localparam int P   = OUT / 2;
  localparam int NP  = P * P;
  localparam int DW  = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  conv_done;
  logic [OUT*OUT*DW-1:0] result;
  logic [NP*DW-1:0]      pool_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic                  out_last;
  logic                  busy;
  logic                  pool_done;

  int n_checks = 0;
  int n_errors = 0;
  int img [OUT][OUT];
  int exp_q[$];
  int got_q[$];

  conv_pool_relu_stream #(.OUT(OUT), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .conv_done   (conv_done),
    .result      (result),
    .pool_result (pool_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy),
    .pool_done   (pool_done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed max over each 2x2 window, floor mode, optional clamp at zero.
  task automatic build_expected();
    int best;
    exp_q.delete();
    for (int r = 0; r < P; r++) begin
      for (int c = 0; c < P; c++) begin
        best = img[2*r][2*c];
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++)
            if (img[2*r+dr][2*c+dc] > best) best = img[2*r+dr][2*c+dc];
`ifdef POOL_RELU_EN
        if (best < 0) best = 0;
`endif
        exp_q.push_back(best & 32'hFFFF);
      end
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < OUT; j++)
        result[(i*OUT+j)*DW +: DW] = 16'(img[i][j]);
  endtask

  task automatic scramble_bus();
    for (int k = 0; k < OUT*OUT; k++) result[k*DW +: DW] = 16'($urandom);
  endtask

  task automatic nominal_img();
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < OUT; j++)
        img[i][j] = 9 * (9*i + j + 11);
  endtask

  task automatic signed_img();
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < OUT; j++)
        img[i][j] = -5;
    img[0][0] = -100; img[0][1] = 3; img[1][0] = -2; img[1][1] = 7;
  endtask

  task automatic random_img();
    for (int i = 0; i < OUT; i++)
      for (int j = 0; j < OUT; j++) begin
        case ($urandom_range(0, 7))
          0:       img[i][j] = -32768;
          1:       img[i][j] = 32767;
          default: img[i][j] = int'($urandom_range(0, 65535)) - 32768;
        endcase
      end
  endtask

  // mode 0: ready high, 1: ready 1,0,0,1 repeating, 2: random ready, 3: ready high plus retriggers
  task automatic run_frame(input int mode);
    int  cyc;
    int  held;
    bit  held_last;
    bit  stall;
    bit  done_seen;
    build_expected();
    drive_bus();
    got_q.delete();
    @(negedge clk);
    conv_done = 1'b1;
    cyc = 0; stall = 1'b0; done_seen = 1'b0; held = 0; held_last = 1'b0;
    while (!done_seen && cyc < 400) begin
      case (mode)
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2:       out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b1;
      endcase
      if (stall) begin
        check_val("stall_valid", out_valid, 1);
        check_val("stall_data", out_data, held);
        check_val("stall_last", out_last, held_last);
      end
      stall = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          check_val($sformatf("last_flag[%0d]", got_q.size()), out_last, (got_q.size() == NP-1));
          got_q.push_back(int'(out_data));
        end else begin
          stall = 1'b1; held = int'(out_data); held_last = out_last;
        end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
      done_seen = pool_done;
      if (cyc == 2) conv_done = 1'b0;
      if (mode == 3) begin
        if (cyc == 4 || cyc == 14) begin
          conv_done = 1'b1;
          scramble_bus();
          check_val($sformatf("retrig_busy@%0d", cyc), busy, 1);
        end
        if (cyc == 6 || cyc == 16) conv_done = 1'b0;
      end
    end
    check_val("pool_done_seen", done_seen, 1);
    if (mode == 0 || mode == 3) check_val("latency", cyc, 20);
    check_val("n_xfers", got_q.size(), NP);
    for (int k = 0; k < NP; k++) begin
      if (k < got_q.size()) check_val($sformatf("stream[%0d]", k), got_q[k], exp_q[k]);
      check_val($sformatf("pool_result[%0d]", k), pool_result[k*DW +: DW], exp_q[k]);
    end
    check_val("end_valid", out_valid, 0);
    check_val("end_busy", busy, 0);
    repeat (3) @(negedge clk);
    check_val("done_sticky", pool_done, 1);
    check_val("idle_busy", busy, 0);
  endtask

  task automatic reset_mid_stream();
    int n;
    int cyc;
    nominal_img();
    drive_bus();
    @(negedge clk);
    conv_done = 1'b1; out_ready = 1'b1; n = 0; cyc = 0;
    while (n < 4 && cyc < 100) begin
      if (out_valid && out_ready) n++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 2) conv_done = 1'b0;
    end
    check_val("mid_xfers", n, 4);
    check_val("mid_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_data", out_data, 0);
    check_val("rst_last", out_last, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", pool_done, 0);
    check_val("rst_pool_lo", pool_result[31:0], 0);
    check_val("rst_pool_hi", pool_result[NP*DW-1 -: 32], 0);
    @(negedge clk);
    rst = 1'b0;
    nominal_img();
    run_frame(0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nominal_ref [NP];
    nominal_ref = '{189, 207, 225, 351, 369, 387, 513, 531, 549};
    rst = 1'b1; conv_done = 1'b1; out_ready = 1'b1; result = '0;
    repeat (3) @(negedge clk);
    check_val("reset_valid", out_valid, 0);
    check_val("reset_data", out_data, 0);
    check_val("reset_last", out_last, 0);
    check_val("reset_busy", busy, 0);
    check_val("reset_done", pool_done, 0);
    check_val("reset_pool", pool_result[31:0], 0);
    nominal_img();
    drive_bus();
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_val("held_high_busy", busy, 0);
    check_val("held_high_valid", out_valid, 0);
    conv_done = 1'b0;

    nominal_img();
    run_frame(0);
    for (int k = 0; k < NP; k++)
      if (k < got_q.size()) check_val($sformatf("nominal[%0d]", k), got_q[k], nominal_ref[k]);

    signed_img();
    run_frame(0);
    check_val("signed_00", pool_result[DW-1:0], 7);
`ifdef POOL_RELU_EN
    check_val("signed_01", pool_result[DW +: DW], 16'h0000);
`else
    check_val("signed_01", pool_result[DW +: DW], 16'hFFFB);
`endif

    nominal_img();
    run_frame(1);

    nominal_img();
    run_frame(3);

    reset_mid_stream();

    for (int t = 0; t < 4; t++) begin
      random_img();
      run_frame(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
